ship_ctrl: RTL
==============

Name: ship_ctrl

Overview:
- Sequences the player ship for the asteroid-avoider game.
- Converts left/right button levels into a saturating 0..12 ship position. Auto-repeat is paced by the game tick.
- Runs the play/crash/game-over lifecycle.
- Its position output drives the ship-sprite decoder (position 0 = far left, 12 = far right). Its visible output gates the red ship layer on the 16x16 LED board.

Parameters:
- NUM_POS, 13: number of legal positions, 0..NUM_POS-1.
- CENTER_POS, 6: position loaded on reset and on every game start.
- REPEAT_TICKS, 4: ticks a held button must stay held before each auto-repeat step. Legal range 1..15.
- CRASH_TICKS, 8: length of the crash blink phase, in ticks. Legal range 1..15.

Ports:
- clk  input  1  system clock; the only clock.
- reset  input  1  synchronous reset, active-low (0 = reset). Sampled on the rising edge of clk.
- tick  input  1  one-cycle game-rate pulse.
- btn_l  input  1  left button level, already synchronised.
- btn_r  input  1  right button level, already synchronised.
- start  input  1  one-cycle start request.
- collision  input  1  level from the asteroid/ship overlap check.
- position  output  4  current ship position, 0..NUM_POS-1.
- ship_visible  output  1  1 = draw the ship.
- playing  output  1  1 while in PLAY.
- game_over  output  1  1 while in OVER.

Behaviour:
- Timing: all outputs are registered and update one clk after the cause.
- Reset values: state=IDLE, position=CENTER_POS, ship_visible=1, playing=0, game_over=0. Repeat counter, crash counter and the previous-direction register all clear to 0.
- Reset mid-game returns to IDLE in one cycle, whatever the state.
- States: IDLE, PLAY, CRASH, OVER.
- IDLE:
  - position held at CENTER_POS; buttons ignored.
  - start → PLAY.
- PLAY:
  - Effective direction: dir=L if btn_l&~btn_r, dir=R if btn_r&~btn_l, otherwise NONE. Both pressed counts as NONE.
  - New press: dir≠NONE and dir differs from last cycle's dir. Action: move one step on the next clk, clear the repeat counter.
  - Held press: dir unchanged and ≠NONE. The counter increments on each tick. When it reaches REPEAT_TICKS: move one step and clear the counter.
  - A tick in the same cycle as a new press: the press rule wins and the counter is cleared.
  - dir=NONE: counter cleared, no move.
  - Saturation: L at position 0 and R at position NUM_POS-1 leave position unchanged. Never exceed 0..NUM_POS-1.
  - collision=1 → CRASH on the next clk. Any move requested in that same cycle is discarded.
  - start is ignored.
- CRASH:
  - position frozen.
  - ship_visible toggles on every tick.
  - The crash counter counts ticks. On the CRASH_TICKS-th tick: → OVER, ship_visible forced to 1.
  - Buttons, start and collision are ignored.
- OVER:
  - game_over=1, ship_visible=1, position frozen.
  - start → PLAY, with position reloaded to CENTER_POS and all counters cleared.
- Output decode: playing is 1 exactly in PLAY; game_over is 1 exactly in OVER.
- Arithmetic: position is 4-bit unsigned; counters are 4-bit unsigned. No overflow is possible given the legal parameter ranges.

Optional Feature:
- Macro: SHIP_WRAP_EN.
- Defined: movement wraps at the edges. L at 0 goes to NUM_POS-1; R at NUM_POS-1 goes to 0.
- Undefined: saturating behaviour as specified above.
- All other behaviour is identical either way.

Decomposition:
- Shared package ship_pkg contains:
  - state enum ship_state_t {IDLE, PLAY, CRASH, OVER}.
  - dir enum dir_t {DIR_NONE, DIR_L, DIR_R}.
  - constants POS_W=4, POS_MAX=12, POS_CENTER=6. The sprite decoder uses the same constants.
- One sub-module, hold_repeat, owns:
  - dir decode, previous-dir register and repeat counter;
  - a one-cycle step pulse plus step_dir.
  - ship_ctrl owns the FSM, position register and crash blink.

Test Plan:
1. reset=0 for 2 clks, then release, then start pulse → position=6, playing=1, ship_visible=1.
2. PLAY, btn_r pressed for 1 clk then released → position 6→7 one clk after the press; no further change.
3. PLAY, btn_l held for 12 ticks, REPEAT_TICKS=4 → position 6→5 immediately, then 4 after tick 4, 3 after tick 8, 2 after tick 12. Repeat with btn_l held from position 1: position sticks at 0 (wraps to 12 with SHIP_WRAP_EN).
4. btn_l and btn_r both held → position unchanged. Then release btn_r while btn_l stays held → one step left on the next clk.
5. collision=1 in the same cycle as a new btn_r press → CRASH, position unchanged. ship_visible toggles on each of 8 ticks. After tick 8: game_over=1, ship_visible=1, and buttons have no effect.
6. In OVER, start pulse → PLAY, position=6, game_over=0. Mid-PLAY reset=0 for 1 clk → IDLE, position=6, playing=0.

Source files
------------

// File: rtl/ship_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ship_pkg
// Description : Shared types and constants for the player-ship controller
//               and the ship-sprite decoder.
// Revision    : 1.0  initial release
// ============================================================================
package ship_pkg;

  // Ship lifecycle states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    CRASH = 2'd2,
    OVER  = 2'd3
  } ship_state_t;

  // Effective button direction after resolving simultaneous presses
  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_L    = 2'd1,
    DIR_R    = 2'd2
  } dir_t;

  // Position encoding shared with the sprite decoder
  localparam int POS_W      = 4;
  localparam int POS_MAX    = 12;
  localparam int POS_CENTER = 6;

endpackage : ship_pkg
`default_nettype wire

// File: rtl/hold_repeat.sv
`default_nettype none
// ============================================================================
// Module      : hold_repeat
// Description : Resolves left/right button levels into a direction, detects
//               new presses and paces auto-repeat of a held button from the
//               game tick. Emits a one-cycle step pulse with its direction.
//               State is held cleared while disabled so that every entry into
//               play starts from a clean slate.
// Revision    : 1.0  initial release
// ============================================================================
module hold_repeat
  import ship_pkg::*;
#(
  parameter int REPEAT_TICKS = 4
) (
  input  logic       clk,
  input  logic       reset,       // active-low, synchronous
  input  logic       enable_i,    // high while the game is in play
  input  logic       tick_i,
  input  logic       btn_l_i,
  input  logic       btn_r_i,
  output logic       step_o,
  output logic [1:0] step_dir_o
);

  // Counter value on which the next tick completes a repeat interval
  localparam logic [3:0] REP_LAST = 4'(REPEAT_TICKS - 1);

  dir_t       dir_d;
  dir_t       prev_q;
  logic [3:0] cnt_q;
  logic [3:0] cnt_d;
  logic       new_press;
  logic       held_fire;

  // Direction decode: both buttons together cancel out
  always_comb begin
    dir_d = DIR_NONE;
    if (btn_l_i && !btn_r_i) begin
      dir_d = DIR_L;
    end else if (btn_r_i && !btn_l_i) begin
      dir_d = DIR_R;
    end
  end

  // Press classification and repeat-counter next state; a new press beats a coincident tick
  always_comb begin
    new_press = (dir_d != DIR_NONE) && (dir_d != prev_q);
    held_fire = (dir_d != DIR_NONE) && !new_press && tick_i && (cnt_q == REP_LAST);
    cnt_d     = cnt_q;
    if ((dir_d == DIR_NONE) || new_press || held_fire) begin
      cnt_d = 4'd0;
    end else if (tick_i) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  assign step_o     = enable_i && (new_press || held_fire);
  assign step_dir_o = dir_d;

  // Previous-direction and repeat-counter registers
  always_ff @(posedge clk) begin
    if (!reset || !enable_i) begin
      prev_q <= DIR_NONE;
      cnt_q  <= 4'd0;
    end else begin
      prev_q <= dir_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule : hold_repeat
`default_nettype wire

// File: rtl/ship_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ship_ctrl
// Description : Player-ship sequencer for the asteroid-avoider game. Owns the
//               IDLE/PLAY/CRASH/OVER lifecycle, the ship position register and
//               the crash blink. Button handling lives in hold_repeat.
//               Build option: define SHIP_WRAP_EN to make movement wrap at
//               the board edges instead of saturating.
// Revision    : 1.0  initial release
// ============================================================================
module ship_ctrl
  import ship_pkg::*;
#(
  parameter int NUM_POS      = POS_MAX + 1,
  parameter int CENTER_POS   = POS_CENTER,
  parameter int REPEAT_TICKS = 4,
  parameter int CRASH_TICKS  = 8
) (
  input  logic             clk,
  input  logic             reset,        // active-low, synchronous
  input  logic             tick,
  input  logic             btn_l,
  input  logic             btn_r,
  input  logic             start,
  input  logic             collision,
  output logic [POS_W-1:0] position,
  output logic             ship_visible,
  output logic             playing,
  output logic             game_over
);

  localparam logic [POS_W-1:0] POS_LAST   = POS_W'(NUM_POS - 1);
  localparam logic [POS_W-1:0] POS_HOME   = POS_W'(CENTER_POS);
  localparam logic [3:0]       CRASH_LAST = 4'(CRASH_TICKS - 1);

  ship_state_t      state_q;
  logic [POS_W-1:0] pos_q;
  logic [POS_W-1:0] pos_d;
  logic             visible_q;
  logic             playing_q;
  logic             over_q;
  logic [3:0]       crash_cnt_q;
  logic             step;
  logic [1:0]       step_dir;

  hold_repeat #(
    .REPEAT_TICKS (REPEAT_TICKS)
  ) u_hold_repeat (
    .clk        (clk),
    .reset      (reset),
    .enable_i   (state_q == PLAY),
    .tick_i     (tick),
    .btn_l_i    (btn_l),
    .btn_r_i    (btn_r),
    .step_o     (step),
    .step_dir_o (step_dir)
  );

  // One-step neighbour of the current position in the requested direction
  always_comb begin
    pos_d = pos_q;
    if (step_dir == DIR_L) begin
`ifdef SHIP_WRAP_EN
      pos_d = (pos_q == '0) ? POS_LAST : pos_q - 1'b1;
`else
      pos_d = (pos_q == '0) ? pos_q : pos_q - 1'b1;
`endif
    end else if (step_dir == DIR_R) begin
`ifdef SHIP_WRAP_EN
      pos_d = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
`else
      pos_d = (pos_q == POS_LAST) ? pos_q : pos_q + 1'b1;
`endif
    end
  end

  // Lifecycle FSM with registered position, blink and status outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      pos_q       <= POS_HOME;
      visible_q   <= 1'b1;
      playing_q   <= 1'b0;
      over_q      <= 1'b0;
      crash_cnt_q <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          pos_q <= POS_HOME;
          if (start) begin
            state_q   <= PLAY;
            playing_q <= 1'b1;
          end
        end
        PLAY: begin
          // A collision discards any move requested in the same cycle
          if (collision) begin
            state_q     <= CRASH;
            playing_q   <= 1'b0;
            crash_cnt_q <= 4'd0;
          end else if (step) begin
            pos_q <= pos_d;
          end
        end
        CRASH: begin
          if (tick) begin
            if (crash_cnt_q == CRASH_LAST) begin
              state_q     <= OVER;
              over_q      <= 1'b1;
              visible_q   <= 1'b1;
              crash_cnt_q <= 4'd0;
            end else begin
              crash_cnt_q <= crash_cnt_q + 4'd1;
              visible_q   <= ~visible_q;
            end
          end
        end
        OVER: begin
          if (start) begin
            state_q     <= PLAY;
            playing_q   <= 1'b1;
            over_q      <= 1'b0;
            pos_q       <= POS_HOME;
            visible_q   <= 1'b1;
            crash_cnt_q <= 4'd0;
          end
        end
      endcase
    end
  end

  assign position     = pos_q;
  assign ship_visible = visible_q;
  assign playing      = playing_q;
  assign game_over    = over_q;

endmodule : ship_ctrl
`default_nettype wire
